// File: rtl/mem_stage.sv
// Memory-access pipeline stage: accepts one op from execute, runs loads/stores
// over a req/ack memory port and hands a registered completion bundle to writeback.
module mem_stage #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic        ex_rd_mem,
  input  logic        ex_wr_mem,
  input  logic [2:0]  ex_dest,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_sdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [41:0] exec_out,
  output logic [31:0] data_in,
  output logic        err,
  input  logic        err_clr
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_wr_q, mem_wr_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]    dest_q, dest_d;
  logic          we_q, we_d;
  logic          wb_valid_q, wb_valid_d;
  logic [41:0]   exec_out_q, exec_out_d;
  logic [31:0]   data_in_q, data_in_d;
  logic          err_q, err_d;

  logic is_mem_op, illegal_op;

  assign is_mem_op  = ex_rd_mem | ex_wr_mem;
  assign illegal_op = (ex_rd_mem & ex_wr_mem) | (ex_alu[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dest_d      = dest_q;
    we_d        = we_q;
    wb_valid_d  = 1'b0;
    exec_out_d  = '0;
    data_in_d   = data_in_q;
    // err_clr is applied first so a same-cycle set below wins
    err_d       = err_q & ~err_clr;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem_op) begin
            wb_valid_d = 1'b1;
            exec_out_d = {5'b0, ex_dest, ex_alu, 1'b0, ex_we};
          end else if (illegal_op) begin
            wb_valid_d = 1'b1;
            err_d      = 1'b1;
          end else begin
            mem_req_d   = 1'b1;
            mem_wr_d    = ex_wr_mem;
            mem_addr_d  = ex_alu;
            mem_wdata_d = ex_sdata;
            dest_d      = ex_dest;
            we_d        = ex_we;
            cnt_d       = '0;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          mem_wr_d   = 1'b0;
          wb_valid_d = 1'b1;
          state_d    = IDLE;
          if (mem_wr_q) begin
            exec_out_d = {5'b0, dest_q, mem_addr_q, 2'b00};
          end else begin
            exec_out_d = {5'b0, dest_q, mem_addr_q, 1'b1, we_q};
            data_in_d  = mem_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: squashed completion so writeback never stalls
          mem_req_d  = 1'b0;
          mem_wr_d   = 1'b0;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      dest_q      <= '0;
      we_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      exec_out_q  <= '0;
      data_in_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dest_q      <= dest_d;
      we_q        <= we_d;
      wb_valid_q  <= wb_valid_d;
      exec_out_q  <= exec_out_d;
      data_in_q   <= data_in_d;
      err_q       <= err_d;
    end
  end

  assign ex_ready  = (state_q == IDLE);
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign exec_out  = exec_out_q;
  assign data_in   = data_in_q;
  assign err       = err_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the RISC core, between execute and writeback. It accepts one operation at a time from execute over a valid/ready handshake and performs loads and stores on the data memory through a req/ack handshake. It presents the completed operation to writeback as the 42-bit `exec_out` bundle plus `data_in` (load data). ALU-only operations pass through with one cycle of latency.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of cycles `mem_req` is held without `mem_ack` before the access is aborted (must be ≥1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  execute presents an operation.
- `ex_ready`  out  1  stage can accept; combinational, equals (state==IDLE).
- `ex_we`  in  1  operation writes the register file.
- `ex_rd_mem`  in  1  load.
- `ex_wr_mem`  in  1  store.
- `ex_dest`  in  3  destination register.
- `ex_alu`  in  32  ALU result; this is the byte address for loads and stores.
- `ex_sdata`  in  32  store data.
- `mem_req`, `mem_wr`  out  1,1  registered memory request and write strobe.
- `mem_addr`, `mem_wdata`  out  32,32  registered address and write data.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req`=1.
- `mem_rdata`  in  32  load data, valid with `mem_ack`.
- `wb_valid`  out  1  registered one-cycle completion pulse.
- `exec_out`  out  42  registered bundle:
  - [0] register write enable;
  - [1] select memory data;
  - [33:2] ALU result;
  - [36:34] dest;
  - [41:37] always 0.
- `data_in`  out  32  registered load data.
- `err`  out  1  sticky error flag.
- `err_clr`  in  1  synchronous clear for `err`.

## Operation
- States are IDLE and BUSY.
- Accept: an operation is accepted when `ex_valid` && `ex_ready`.
- IDLE, accept of a non-memory op (`ex_rd_mem`=`ex_wr_mem`=0):
  - Next cycle `wb_valid`=1 and `exec_out` = {5'b0, `ex_dest`, `ex_alu`, 1'b0, `ex_we`}.
  - State stays IDLE.
- IDLE, accept of a load or store with `ex_alu`[1:0]=0 and only one of `ex_rd_mem`/`ex_wr_mem` set:
  - Latch dest, we, address and store data.
  - Next cycle: `mem_req`=1, `mem_wr`=`ex_wr_mem`, address and data driven; state becomes BUSY.
- IDLE, accept of a misaligned address, or with both `ex_rd_mem` and `ex_wr_mem` set:
  - No memory request is issued; `err` is set.
  - Next cycle `wb_valid`=1 with `exec_out`=0 (squashed). State stays IDLE.
- BUSY:
  - `mem_req`, `mem_wr`, `mem_addr` and `mem_wdata` are held stable.
  - A timeout counter of width $clog2(MEM_TIMEOUT+1) counts cycles with `mem_req`=1.
- BUSY, `mem_ack`=1:
  - Next cycle `mem_req`=0, `wb_valid`=1, state IDLE.
  - Load: `data_in`←`mem_rdata`; `exec_out` = {5'b0, dest, latched addr, 1'b1, we}.
  - Store: `exec_out` = {5'b0, dest, addr, 1'b0, 1'b0}; a store never writes the register file.
- BUSY, counter reaches MEM_TIMEOUT with no ack:
  - Next cycle `mem_req`=0, `err`=1, `wb_valid`=1 with `exec_out`=0, state IDLE.
  - An ack in the timeout cycle wins; the access completes normally.
- `exec_out` is 0 on every cycle where `wb_valid`=0, so writeback sees we=0 on bubbles.
- `data_in` holds its last load value until the next load completes.
- `err` is set by a misaligned/illegal op or by a timeout, and cleared by `err_clr`. When set and clear coincide, set wins.

## Timing
- Reset (async, immediate) forces:
  - state IDLE, counter 0;
  - `mem_req`, `mem_wr`, `mem_addr`, `mem_wdata` = 0;
  - `wb_valid`, `exec_out`, `data_in`, `err` = 0.
- `ex_ready`=1 after reset.
- A reset asserted mid-access drops `mem_req` immediately and discards the operation; no `wb_valid` follows.
- Non-memory ops: 1-cycle latency, back-to-back throughput of 1 op/cycle.
- Memory op accepted at cycle 0:
  - `mem_req` rises at cycle 1.
  - With ack at cycle k≥1, `wb_valid` occurs at k+1, `ex_ready` returns to 1 at k+1, and the next accept can happen at k+1.
  - An ack in cycle 1 (same cycle `mem_req` first asserts) is legal: `wb_valid` at cycle 2.
- An ack while `mem_req`=0 is ignored.

## Test plan
- Back-to-back ALU ops (dest=3, alu=0x1234, we=1), then (dest=5, alu=0xFF, we=1) -> `wb_valid` on two consecutive cycles, `exec_out`[36:34]=3 then 5, [33:2]=0x1234 then 0xFF, [1]=0, [0]=1.
- Load addr 0x40, ack after 3 cycles with rdata 0xDEADBEEF -> `mem_req` held 3 cycles, `wb_valid` one cycle after ack, `data_in`=0xDEADBEEF, `exec_out`[1:0]=2'b11; `ex_ready`=0 throughout the access.
- Store addr 0x80, data 0xA5A5A5A5, `ex_we`=1, ack in first `mem_req` cycle -> `mem_wr`=1, `mem_wdata`=0xA5A5A5A5, `wb_valid` at cycle 2, `exec_out`[0]=0.
- Load with MEM_TIMEOUT=4 and no ack -> `mem_req` high exactly 4 cycles, then `err`=1 and a squashed `wb_valid` (`exec_out`=0). Pulsing `err_clr` afterwards -> `err`=0.
- Load addr 0x41 -> no `mem_req`, `err`=1, squashed `wb_valid` next cycle. Op with both rd/wr set -> same response.
- `rst_n` low during BUSY -> `mem_req` and all outputs 0 asynchronously, no `wb_valid` after release, and a new op is accepted normally.
